// File: rtl/panel_ctrl_pkg.sv
// Shared front-panel constants: debounce counter width and default debounce length.
package panel_ctrl_pkg;

    localparam int                   DB_CNT_W      = 16;
    localparam logic [DB_CNT_W-1:0]  DB_CYCLES_DEF = 16'd50000;

endpackage

// File: rtl/panel_ctrl_btn_debounce.sv
// One push button: 2-flop synchronizer, optional debounce (PANEL_DEBOUNCE_EN), press pulse on rise.
module btn_debounce
    import panel_ctrl_pkg::*;
#(
    parameter logic [DB_CNT_W-1:0] DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_btn,
    output logic o_press
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_stable;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PANEL_DEBOUNCE_EN
    logic [DB_CNT_W-1:0] r_cnt;
    logic                r_stable;

    // Any sample agreeing with the stable level restarts the count from zero.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (r_sync2 == r_stable) begin
            r_cnt    <= '0;
        end else if (r_cnt == DB_CYCLES - DB_CNT_W'(1)) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
        end else begin
            r_cnt    <= r_cnt + DB_CNT_W'(1);
        end
    end

    assign w_stable = r_stable;
`else
    logic w_unused_db;

    assign w_unused_db = ^DB_CYCLES;
    assign w_stable    = r_sync2;
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_stable;
        end
    end

    assign o_press = w_stable & ~r_prev;

endmodule

// File: rtl/panel_ctrl.sv
// Front-panel run/step control; debounce per button is enabled by macro PANEL_DEBOUNCE_EN.
module panel_ctrl
    import panel_ctrl_pkg::*;
#(
    parameter logic [DB_CNT_W-1:0] DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_run,
    input  logic btn_step_phase,
    input  logic btn_step_inst,
    input  logic halt,
    input  logic running,
    output logic run,
    output logic step_phase,
    output logic step_inst
);

    logic w_press_run;
    logic w_press_phase;
    logic w_press_inst;
    logic w_run_next;
    logic w_step_ok;
    logic r_run;
    logic r_step_phase;
    logic r_step_inst;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
        .i_clock   (clock),
        .i_reset_n (reset),
        .i_btn     (btn_run),
        .o_press   (w_press_run)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_phase (
        .i_clock   (clock),
        .i_reset_n (reset),
        .i_btn     (btn_step_phase),
        .o_press   (w_press_phase)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inst (
        .i_clock   (clock),
        .i_reset_n (reset),
        .i_btn     (btn_step_inst),
        .o_press   (w_press_inst)
    );

    assign w_run_next = halt ? 1'b0 : (w_press_run ? ~r_run : r_run);
    // A step is also refused when run rises at the same edge, so no pulse ever overlaps run=1.
    assign w_step_ok  = ~r_run & ~running & ~w_run_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_run        <= 1'b0;
            r_step_phase <= 1'b0;
            r_step_inst  <= 1'b0;
        end else begin
            r_run        <= w_run_next;
            r_step_inst  <= w_press_inst & w_step_ok;
            r_step_phase <= w_press_phase & ~w_press_inst & w_step_ok;
        end
    end

    assign run        = r_run;
    assign step_phase = r_step_phase;
    assign step_inst  = r_step_inst;

endmodule

// File: tb/tb_panel_ctrl.sv
// Directed bench for panel_ctrl (DB_CYCLES=4) with a window-based reference model.
module tb_panel_ctrl;

    localparam int DB = 4;
`ifdef PANEL_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif
    // Clock edges from first button sample to the output reacting.
    localparam int LAT = DB_EN ? (DB + 3) : 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic btn_run = 1'b0;
    logic btn_step_phase = 1'b0;
    logic btn_step_inst = 1'b0;
    logic halt = 1'b0;
    logic running = 1'b0;
    logic run;
    logic step_phase;
    logic step_inst;

    int nchk = 0;
    int nerr = 0;
    int si_cnt = 0;
    int sp_cnt = 0;

    panel_ctrl #(.DB_CYCLES(16'(DB))) dut (
        .clock          (clock),
        .reset          (reset),
        .btn_run        (btn_run),
        .btn_step_phase (btn_step_phase),
        .btn_step_inst  (btn_step_inst),
        .halt           (halt),
        .running        (running),
        .run            (run),
        .step_phase     (step_phase),
        .step_inst      (step_inst)
    );

    initial forever #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Index 0 = run, 1 = step_phase, 2 = step_inst.
    bit m_s1 [3];
    bit m_s2 [3];
    bit m_stab [3];
    bit m_prev [3];
    bit m_win [3][$];
    bit m_pr [3];
    bit m_run, m_sp, m_si, m_nrun, m_ok, m_diff;

    function automatic bit raw(input int b);
        case (b)
            0:       return btn_run;
            1:       return btn_step_phase;
            default: return btn_step_inst;
        endcase
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 3; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_stab[b] = 0; m_prev[b] = 0;
                m_win[b].delete();
            end
            m_run = 0; m_sp = 0; m_si = 0;
        end else begin
            for (int b = 0; b < 3; b++) m_pr[b] = m_stab[b] && !m_prev[b];
            m_nrun = halt ? 1'b0 : (m_pr[0] ? !m_run : m_run);
            m_ok   = !m_run && !running && !m_nrun;
            m_si   = m_pr[2] && m_ok;
            m_sp   = m_pr[1] && !m_pr[2] && m_ok;
            m_run  = m_nrun;
            for (int b = 0; b < 3; b++) begin
                m_prev[b] = m_stab[b];
                if (DB_EN) begin
                    // Accept a new level once the last DB synchronized samples all disagree with it.
                    m_win[b].push_back(m_s2[b]);
                    if (m_win[b].size() > DB) void'(m_win[b].pop_front());
                    if (m_win[b].size() == DB) begin
                        m_diff = 1;
                        for (int i = 0; i < DB; i++) if (m_win[b][i] == m_stab[b]) m_diff = 0;
                        if (m_diff) m_stab[b] = !m_stab[b];
                    end
                end else begin
                    m_stab[b] = m_s1[b];
                end
                m_s2[b] = m_s1[b];
                m_s1[b] = raw(b);
            end
        end
    end

    always @(posedge clock) begin
        #1;
        chk("run_model", run, m_run);
        chk("step_phase_model", step_phase, m_sp);
        chk("step_inst_model", step_inst, m_si);
        chk("step_exclusive", step_phase && step_inst, 0);
        chk("step_during_run", (step_phase || step_inst) && run, 0);
        if (step_inst) si_cnt++;
        if (step_phase) sp_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       btn_run = v;
            1:       btn_step_phase = v;
            default: btn_step_inst = v;
        endcase
    endtask

    task automatic hold(input int b, input int n);
        set_btn(b, 1'b1);
        tick(n);
        set_btn(b, 1'b0);
        tick(8);
    endtask

    // Called at a falling edge with the button already asserted; returns edge index of first reaction.
    task automatic measure(input int b, output int lat, output int rises);
        logic last;
        lat = -1;
        rises = 0;
        last = (b == 0) ? run : step_inst;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            #1;
            if (((b == 0) ? run : step_inst) && !last) begin
                rises++;
                if (lat < 0) lat = k;
            end
            last = (b == 0) ? run : step_inst;
        end
        tick(1);
    endtask

    int lat, rises;

    initial begin
        @(posedge clock);
        #1;
        chk("reset_run", run, 0);
        chk("reset_step_phase", step_phase, 0);
        chk("reset_step_inst", step_inst, 0);
        tick(2);
        reset = 1'b1;
        tick(3);

        // Run toggle latency and second press.
        set_btn(0, 1'b1);
        measure(0, lat, rises);
        chk("run_rise_latency", lat, LAT);
        chk("run_rise_count", rises, 1);
        set_btn(0, 1'b0);
        tick(10);
        chk("run_held_on", run, 1);
        hold(0, 20);
        tick(2);
        chk("run_second_press_off", run, 0);

        // Short glitches on step_inst, then a clean held press.
        si_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            set_btn(2, 1'b1);
            tick(3);
            set_btn(2, 1'b0);
            tick(2);
        end
        tick(8);
        chk("glitch_step_inst_count", si_cnt, DB_EN ? 0 : 6);
        si_cnt = 0;
        set_btn(2, 1'b1);
        measure(2, lat, rises);
        set_btn(2, 1'b0);
        tick(10);
        chk("step_inst_latency", lat, LAT);
        chk("step_inst_once", si_cnt, 1);

        // Steps dropped while run=1 or running=1.
        hold(0, 12);
        chk("run_on_for_block", run, 1);
        sp_cnt = 0;
        hold(1, 12);
        chk("step_phase_blocked_by_run", sp_cnt, 0);
        hold(0, 12);
        chk("run_off_again", run, 0);
        running = 1'b1;
        si_cnt = 0;
        hold(2, 12);
        chk("step_inst_blocked_by_running", si_cnt, 0);
        running = 1'b0;
        hold(2, 12);
        chk("step_inst_after_running", si_cnt, 1);

        // Halt wins over a run press in the same cycle.
        set_btn(0, 1'b1);
        tick(LAT - 1);
        halt = 1'b1;
        tick(1);
        halt = 1'b0;
        tick(10);
        set_btn(0, 1'b0);
        tick(8);
        chk("halt_priority", run, 0);
        hold(0, 12);
        chk("run_on_before_halt", run, 1);
        halt = 1'b1;
        @(posedge clock);
        #1;
        chk("halt_clears_run", run, 0);
        tick(1);
        halt = 1'b0;
        tick(4);

        // Simultaneous step presses: only step_inst.
        si_cnt = 0;
        sp_cnt = 0;
        btn_step_phase = 1'b1;
        btn_step_inst = 1'b1;
        tick(12);
        btn_step_phase = 1'b0;
        btn_step_inst = 1'b0;
        tick(8);
        chk("dual_step_inst", si_cnt, 1);
        chk("dual_step_phase", sp_cnt, 0);

        // Asynchronous reset mid-count while run=1, button held through release.
        hold(0, 12);
        chk("run_on_before_reset", run, 1);
        set_btn(0, 1'b1);
        tick(2);
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset_run", run, 0);
        chk("async_reset_step_phase", step_phase, 0);
        chk("async_reset_step_inst", step_inst, 0);
        tick(2);
        reset = 1'b1;
        measure(0, lat, rises);
        chk("held_through_reset_latency", lat, LAT);
        chk("held_through_reset_count", rises, 1);
        set_btn(0, 1'b0);
        tick(6);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
